// File: rtl/sata_cont_inserter.sv
// Transmit-side SATA CONT inserter: collapses runs of a repeated continuable primitive into P P CONT junk...
// Define SATA_CONT_JUNK_LFSR_EN for LFSR junk; otherwise junk is the constant D10.2 pattern.
module sata_cont_inserter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_data,
  input  logic        i_datak,
  output logic [31:0] o_data,
  output logic        o_datak
);

  localparam logic        DWORD_IS_PRIM = 1'b1;
  localparam logic [31:0] ALIGN_PRIM    = 32'h7B4A_4ABC;
  localparam logic [31:0] CONT_PRIM     = 32'h9999_AA7C;
  localparam logic [31:0] SOF_PRIM      = 32'h3737_B57C;
  localparam logic [31:0] EOF_PRIM      = 32'hD5D5_B57C;

  typedef enum logic {ST_PASS, ST_JUNK} state_t;

  state_t      state_reg;
  logic [31:0] last_reg;
  logic        last_vld;
  logic [1:0]  cnt_reg;
  logic [31:0] junk_word;

  logic is_prim, is_align, is_noncont, is_contable, same_as_last;

  always_comb begin
    is_prim      = (i_datak == DWORD_IS_PRIM);
    is_align     = is_prim && (i_data == ALIGN_PRIM);
    is_noncont   = is_prim && ((i_data == CONT_PRIM) || (i_data == SOF_PRIM) ||
                               (i_data == EOF_PRIM));
    is_contable  = is_prim && !is_align && !is_noncont;
    same_as_last = is_contable && last_vld && (i_data == last_reg);
  end

`ifdef SATA_CONT_JUNK_LFSR_EN
  // Galois LFSR, x^32+x^22+x^2+x+1; junk is the current state, advanced per junk dword.
  logic [31:0] lfsr_reg;
  logic        junk_advance;

  assign junk_word    = lfsr_reg;
  assign junk_advance = !is_align && (state_reg == ST_JUNK) && same_as_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_reg <= 32'hFFFF_FFFF;
    end else if (junk_advance) begin
      lfsr_reg <= (lfsr_reg >> 1) ^ (lfsr_reg[0] ? 32'h8020_0003 : 32'h0000_0000);
    end
  end
`else
  assign junk_word = 32'h4A4A_4A4A;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      o_data    <= 32'h0000_0000;
      o_datak   <= 1'b0;
      state_reg <= ST_PASS;
      last_reg  <= 32'h0000_0000;
      last_vld  <= 1'b0;
      cnt_reg   <= 2'd0;
    end else if (is_align) begin
      // ALIGN is transparent to the run tracking.
      o_data  <= i_data;
      o_datak <= i_datak;
    end else if ((state_reg == ST_JUNK) && same_as_last) begin
      o_data  <= junk_word;
      o_datak <= 1'b0;
    end else if ((state_reg == ST_PASS) && same_as_last && (cnt_reg == 2'd2)) begin
      o_data    <= CONT_PRIM;
      o_datak   <= DWORD_IS_PRIM;
      state_reg <= ST_JUNK;
    end else begin
      o_data    <= i_data;
      o_datak   <= i_datak;
      state_reg <= ST_PASS;
      if (same_as_last) begin
        cnt_reg <= (cnt_reg == 2'd2) ? 2'd2 : cnt_reg + 2'd1;
      end else if (is_contable) begin
        last_reg <= i_data;
        last_vld <= 1'b1;
        cnt_reg  <= 2'd1;
      end else begin
        last_vld <= 1'b0;
        cnt_reg  <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_sata_cont_inserter.sv
// Directed bench for sata_cont_inserter; compares {o_datak,o_data} per cycle against hand-written vectors.
module tb_sata_cont_inserter;

  localparam logic [31:0] ALIGN = 32'h7B4A_4ABC;
  localparam logic [31:0] CONT  = 32'h9999_AA7C;
  localparam logic [31:0] SOF   = 32'h3737_B57C;
  localparam logic [31:0] SYNC  = 32'hB5B5_957C;
  localparam logic [31:0] HOLD  = 32'hD5D5_AA7C;
  localparam logic [31:0] X_RDY = 32'h5757_B57C;
  localparam logic [31:0] R_IP  = 32'h5555_B57C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_data = 32'h0;
  logic        i_datak = 1'b0;
  logic [31:0] o_data;
  logic        o_datak;

  int checks = 0;
  int failures = 0;
  logic [31:0] junk_exp [0:4];

  sata_cont_inserter dut (
    .clk     (clk),
    .reset   (reset),
    .i_data  (i_data),
    .i_datak (i_datak),
    .o_data  (o_data),
    .o_datak (o_datak)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got k=%0b d=%08h, expected k=%0b d=%08h",
               tag, got[32], got[31:0], exp[32], exp[31:0]);
    end else begin
      $display("ok   %s: k=%0b d=%08h", tag, got[32], got[31:0]);
    end
  endtask

  // Apply one dword, clock it, and check the registered output one cycle later.
  task automatic step(input string tag, input logic [31:0] d, input logic k,
                      input logic [31:0] ed, input logic ek);
    i_data  = d;
    i_datak = k;
    @(posedge clk);
    #1;
    check_eq(tag, {o_datak, o_data}, {ek, ed});
  endtask

  task automatic prim(input string tag, input logic [31:0] p, input logic [31:0] ed, input logic ek);
    step(tag, p, 1'b1, ed, ek);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_data = 32'h0;
    i_datak = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
`ifdef SATA_CONT_JUNK_LFSR_EN
    junk_exp[0] = 32'hFFFF_FFFF;
    junk_exp[1] = 32'hFFDF_FFFC;
    junk_exp[2] = 32'h7FEF_FFFE;
    junk_exp[3] = 32'h3FF7_FFFF;
    junk_exp[4] = 32'h9FDB_FFFC;
`else
    for (int i = 0; i < 5; i++) junk_exp[i] = 32'h4A4A_4A4A;
`endif

    // Reset state
    do_reset();
    check_eq("reset_out", {o_datak, o_data}, 33'h0);

    // Six SYNC: S S CONT J J J
    prim("t1_sync0", SYNC, SYNC, 1'b1);
    prim("t1_sync1", SYNC, SYNC, 1'b1);
    prim("t1_cont",  SYNC, CONT, 1'b1);
    prim("t1_junk0", SYNC, junk_exp[0], 1'b0);
    prim("t1_junk1", SYNC, junk_exp[1], 1'b0);
    prim("t1_junk2", SYNC, junk_exp[2], 1'b0);

    // HOLD HOLD ALIGN HOLD HOLD -> HOLD HOLD ALIGN CONT J
    do_reset();
    prim("t2_hold0", HOLD, HOLD, 1'b1);
    prim("t2_hold1", HOLD, HOLD, 1'b1);
    prim("t2_align", ALIGN, ALIGN, 1'b1);
    prim("t2_cont",  HOLD, CONT, 1'b1);
    prim("t2_junk0", HOLD, junk_exp[0], 1'b0);

    // SYNC x8 then X_RDY x3, with an ALIGN inside the junk region
    do_reset();
    prim("t3_sync0", SYNC, SYNC, 1'b1);
    prim("t3_sync1", SYNC, SYNC, 1'b1);
    prim("t3_cont",  SYNC, CONT, 1'b1);
    prim("t3_junk0", SYNC, junk_exp[0], 1'b0);
    prim("t3_junk1", SYNC, junk_exp[1], 1'b0);
    prim("t3_align", ALIGN, ALIGN, 1'b1);
    prim("t3_junk2", SYNC, junk_exp[2], 1'b0);
    prim("t3_junk3", SYNC, junk_exp[3], 1'b0);
    prim("t3_junk4", SYNC, junk_exp[4], 1'b0);
    prim("t3_xrdy0", X_RDY, X_RDY, 1'b1);
    prim("t3_xrdy1", X_RDY, X_RDY, 1'b1);
    prim("t3_xcont", X_RDY, CONT, 1'b1);

    // Data breaks an R_IP run
    do_reset();
    prim("t4_rip0", R_IP, R_IP, 1'b1);
    prim("t4_rip1", R_IP, R_IP, 1'b1);
    step("t4_data", 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0);
    prim("t4_rip2", R_IP, R_IP, 1'b1);
    prim("t4_rip3", R_IP, R_IP, 1'b1);
    prim("t4_cont", R_IP, CONT, 1'b1);

    // Non-continuable primitives never produce CONT
    do_reset();
    for (int i = 0; i < 4; i++) prim($sformatf("t5_sof%0d", i), SOF, SOF, 1'b1);
    for (int i = 0; i < 3; i++) prim($sformatf("t5_cont%0d", i), CONT, CONT, 1'b1);

    // One-cycle reset in mid-junk, then SYNC continues
    do_reset();
    prim("t6_sync0", SYNC, SYNC, 1'b1);
    prim("t6_sync1", SYNC, SYNC, 1'b1);
    prim("t6_cont",  SYNC, CONT, 1'b1);
    prim("t6_junk0", SYNC, junk_exp[0], 1'b0);
    prim("t6_junk1", SYNC, junk_exp[1], 1'b0);
    reset = 1'b1;
    prim("t6_inrst", SYNC, 32'h0, 1'b0);
    reset = 1'b0;
    prim("t6_sync2", SYNC, SYNC, 1'b1);
    prim("t6_sync3", SYNC, SYNC, 1'b1);
    prim("t6_cont2", SYNC, CONT, 1'b1);
    prim("t6_junkr", SYNC, junk_exp[0], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
